swt16_hazard_ctrl: RTL and testbench
====================================

// Module: swt16_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the swt16 pipeline generations after the fixed 5-stage core.
//  Tracks in-flight register writes across PIPE_DEPTH post-decode stages in a scoreboard shift register.
//  Selects forwarding sources for DC operands, stalls DC on load-use hazards, and sequences multi-cycle flushes on taken branches.
//  Sits beside decoder/exec. Drives the decoder stall, the flush into fetch/decode/exec, and the operand mux selects.
// PARAMETERS
//  REG_IDX_WIDTH  4  register index width (2**REG_IDX_WIDTH registers)
//  PIPE_DEPTH     3  tracked stages after DC; slot 1 = EX, slot PIPE_DEPTH = WB
//  LOAD_STAGE     2  first slot whose load result is forwardable (2 = MEM output)
//  FLUSH_CYCLES   2  cycles out_flush stays high per taken branch (>=1)
//  ZERO_REG_HW    0  1: register 0 never creates a hazard or a forward
//  SEL_W          2  width of forward selects; must satisfy 2**SEL_W > PIPE_DEPTH
// PORTS
//  clock            in   1            rising-edge clock
//  reset            in   1            synchronous, active-high
//  in_dc_valid      in   1            DC holds a real instruction this cycle
//  in_dc_src1_idx   in   REG_IDX_W    src1 register index
//  in_dc_src1_used  in   1            src1 is read
//  in_dc_src2_idx   in   REG_IDX_W    src2 register index
//  in_dc_src2_used  in   1            src2 is read
//  in_dc_dst_idx    in   REG_IDX_W    destination index
//  in_dc_writes     in   1            instruction writes dst
//  in_dc_is_load    in   1            dst comes from DMEM
//  in_branch_taken  in   1            EX resolved a taken branch/jump this cycle
//  out_stall        out  1            hold IF/DC, inject bubble into EX
//  out_flush        out  1            squash IF/DC/EX contents
//  out_fwd_src1_sel out  SEL_W        0 = regfile, k = result of slot k
//  out_fwd_src2_sel out  SEL_W        as src1
//  out_busy_mask    out  2**REG_IDX_W bit r set if any valid slot writes r
// BEHAVIOUR
//  - Scoreboard: slots 1..PIPE_DEPTH, each {valid, dst, is_load}. On every clock, slot k <= slot k-1 for k>=2.
//  - Slot 1 <= {1, dst, is_load} only if in_dc_valid & in_dc_writes & !out_stall & !out_flush. Otherwise slot 1 <= invalid (bubble).
//  - Match(s, k): slot k valid, slot k dst == src idx s, src used, and not (ZERO_REG_HW && s == 0).
//  - Forward select: the lowest k with Match wins (newest producer). No match -> 0. Outputs are combinational from slots and DC inputs.
//  - Load-use stall: out_stall = in_dc_valid & !out_flush & (either src has a winning match k with is_load & k < LOAD_STAGE).
//  - When a stall is active, the forward selects are don't-care. The next cycle re-evaluates after the bubble has advanced.
//  - Flush: flush_cnt has width clog2(FLUSH_CYCLES+1).
//    - in_branch_taken loads flush_cnt = FLUSH_CYCLES-1.
//    - Otherwise flush_cnt decrements while nonzero.
//    - out_flush = in_branch_taken | (flush_cnt != 0).
//    - A branch arriving while flush_cnt != 0 reloads the counter (restart).
//  - Flush has priority over stall. Slots 2..PIPE_DEPTH are never squashed; instructions past EX always retire.
//  - busy_mask is the OR of one-hot(dst) over valid slots. It is combinational.
//  - Reset: all slots invalid and flush_cnt = 0, giving out_stall=0, out_flush=0, selects=0, busy_mask=0 while reset is held with in_dc_valid=0.
//  - Reset asserted mid-flush or mid-stall clears state on the next edge. There is no pending effect afterwards.
//  - Latency: hazard/forward decisions are same-cycle. Scoreboard updates on the following edge.
// TESTING
//  - Reset: assert reset 2 cycles with random inputs -> after release slots empty, out_flush=0, busy_mask=0.
//  - ALU chain: add r3 then use r3 next cycle -> out_fwd_src1_sel=1, out_stall=0.
//  - Same ALU chain, use 2 cycles later -> sel=2; 3 cycles later -> sel=3; 4 cycles later -> sel=0.
//  - Load-use: load r5 then immediate use of r5 (LOAD_STAGE=2) -> out_stall=1 for exactly 1 cycle, then sel=2, bubble visible in slot 1.
//  - Newest wins: r4 written at slots 1 and 3, DC reads r4 -> sel=1. ZERO_REG_HW=1, r0 in slot 1 -> sel=0, no stall.
//  - Flush: in_branch_taken one cycle (FLUSH_CYCLES=2) -> out_flush high 2 cycles, slot 1 bubble both cycles.
//  - Flush restart: second branch on the flush's 2nd cycle -> flush extends to 3 cycles total.
//  - Flush beats stall: branch taken during a load-use hazard -> out_flush=1, out_stall=0.

Source files
------------

// File: rtl/swt16_hazard_ctrl.sv
// swt16 hazard/forwarding controller: tracks in-flight register writes, picks operand
// forwarding sources, stalls on load-use and sequences multi-cycle branch flushes.
module swt16_hazard_ctrl #(
    parameter int unsigned REG_IDX_WIDTH = 4,
    parameter int unsigned PIPE_DEPTH    = 3,
    parameter int unsigned LOAD_STAGE    = 2,
    parameter int unsigned FLUSH_CYCLES  = 2,
    parameter int unsigned ZERO_REG_HW   = 0,
    parameter int unsigned SEL_W         = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            in_dc_valid,
    input  logic [REG_IDX_WIDTH-1:0]        in_dc_src1_idx,
    input  logic                            in_dc_src1_used,
    input  logic [REG_IDX_WIDTH-1:0]        in_dc_src2_idx,
    input  logic                            in_dc_src2_used,
    input  logic [REG_IDX_WIDTH-1:0]        in_dc_dst_idx,
    input  logic                            in_dc_writes,
    input  logic                            in_dc_is_load,
    input  logic                            in_branch_taken,
    output logic                            out_stall,
    output logic                            out_flush,
    output logic [SEL_W-1:0]                out_fwd_src1_sel,
    output logic [SEL_W-1:0]                out_fwd_src2_sel,
    output logic [(2**REG_IDX_WIDTH)-1:0]   out_busy_mask
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

    // Scoreboard slots: index 1 = EX, index PIPE_DEPTH = WB
    logic [PIPE_DEPTH:1]      slot_valid_q;
    logic [PIPE_DEPTH:1]      slot_load_q;
    logic [REG_IDX_WIDTH-1:0] slot_dst_q [1:PIPE_DEPTH];
    logic [CNT_W-1:0]         flush_cnt_q;

    logic                     src1_zero;
    logic                     src2_zero;
    logic [PIPE_DEPTH:1]      match1;
    logic [PIPE_DEPTH:1]      match2;
    logic                     found1;
    logic                     found2;
    logic                     load_use1;
    logic                     load_use2;

    assign src1_zero = (ZERO_REG_HW != 0) && (in_dc_src1_idx == '0);
    assign src2_zero = (ZERO_REG_HW != 0) && (in_dc_src2_idx == '0);

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int unsigned k = 1; k <= PIPE_DEPTH; k++) begin
            match1[k] = slot_valid_q[k] && (slot_dst_q[k] == in_dc_src1_idx)
                        && in_dc_src1_used && !src1_zero;
            match2[k] = slot_valid_q[k] && (slot_dst_q[k] == in_dc_src2_idx)
                        && in_dc_src2_used && !src2_zero;
        end
    end

    // Lowest matching slot is the newest producer and wins the forward
    always_comb begin
        out_fwd_src1_sel = '0;
        out_fwd_src2_sel = '0;
        found1           = 1'b0;
        found2           = 1'b0;
        load_use1        = 1'b0;
        load_use2        = 1'b0;
        for (int unsigned k = 1; k <= PIPE_DEPTH; k++) begin
            if (match1[k] && !found1) begin
                found1           = 1'b1;
                out_fwd_src1_sel = SEL_W'(k);
                load_use1        = slot_load_q[k] && (k < LOAD_STAGE);
            end
            if (match2[k] && !found2) begin
                found2           = 1'b1;
                out_fwd_src2_sel = SEL_W'(k);
                load_use2        = slot_load_q[k] && (k < LOAD_STAGE);
            end
        end
    end

    always_comb begin
        out_busy_mask = '0;
        for (int unsigned k = 1; k <= PIPE_DEPTH; k++) begin
            if (slot_valid_q[k]) begin
                out_busy_mask[slot_dst_q[k]] = 1'b1;
            end
        end
    end

    assign out_flush = in_branch_taken || (flush_cnt_q != '0);
    assign out_stall = in_dc_valid && !out_flush && (load_use1 || load_use2);

    // Slots past EX always advance; only slot 1 takes a bubble on stall/flush
    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid_q <= '0;
            slot_load_q  <= '0;
            flush_cnt_q  <= '0;
            for (int unsigned k = 1; k <= PIPE_DEPTH; k++) begin
                slot_dst_q[k] <= '0;
            end
        end else begin
            slot_valid_q[1] <= in_dc_valid && in_dc_writes && !out_stall && !out_flush;
            slot_load_q[1]  <= in_dc_is_load;
            slot_dst_q[1]   <= in_dc_dst_idx;
            for (int unsigned k = 2; k <= PIPE_DEPTH; k++) begin
                slot_valid_q[k] <= slot_valid_q[k-1];
                slot_load_q[k]  <= slot_load_q[k-1];
                slot_dst_q[k]   <= slot_dst_q[k-1];
            end
            if (in_branch_taken) begin
                flush_cnt_q <= CNT_W'(FLUSH_CYCLES - 1);
            end else if (flush_cnt_q != '0) begin
                flush_cnt_q <= flush_cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_swt16_hazard_ctrl.sv
// Bench for swt16_hazard_ctrl: directed scenarios with literal expectations plus
// random traffic checked every cycle against a queue-based reference model.
module tb_swt16_hazard_ctrl;

    localparam int unsigned RW = 4;
    localparam int unsigned PD = 3;
    localparam int unsigned LS = 2;
    localparam int unsigned FC = 2;
    localparam int unsigned ZR = 1;
    localparam int unsigned SW = 2;
    localparam int unsigned NR = 2 ** RW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_dc_valid = 1'b0;
    logic [RW-1:0] in_dc_src1_idx = '0;
    logic          in_dc_src1_used = 1'b0;
    logic [RW-1:0] in_dc_src2_idx = '0;
    logic          in_dc_src2_used = 1'b0;
    logic [RW-1:0] in_dc_dst_idx = '0;
    logic          in_dc_writes = 1'b0;
    logic          in_dc_is_load = 1'b0;
    logic          in_branch_taken = 1'b0;
    logic          out_stall;
    logic          out_flush;
    logic [SW-1:0] out_fwd_src1_sel;
    logic [SW-1:0] out_fwd_src2_sel;
    logic [NR-1:0] out_busy_mask;

    always #5 clock = ~clock;

    swt16_hazard_ctrl #(
        .REG_IDX_WIDTH (RW),
        .PIPE_DEPTH    (PD),
        .LOAD_STAGE    (LS),
        .FLUSH_CYCLES  (FC),
        .ZERO_REG_HW   (ZR),
        .SEL_W         (SW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .in_dc_valid      (in_dc_valid),
        .in_dc_src1_idx   (in_dc_src1_idx),
        .in_dc_src1_used  (in_dc_src1_used),
        .in_dc_src2_idx   (in_dc_src2_idx),
        .in_dc_src2_used  (in_dc_src2_used),
        .in_dc_dst_idx    (in_dc_dst_idx),
        .in_dc_writes     (in_dc_writes),
        .in_dc_is_load    (in_dc_is_load),
        .in_branch_taken  (in_branch_taken),
        .out_stall        (out_stall),
        .out_flush        (out_flush),
        .out_fwd_src1_sel (out_fwd_src1_sel),
        .out_fwd_src2_sel (out_fwd_src2_sel),
        .out_busy_mask    (out_busy_mask)
    );

    int n_vec  = 0;
    int n_miss = 0;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: queue of issued writes (entry 0 = newest = EX) and cycles since last branch
    typedef struct {
        bit v;
        int dst;
        bit ld;
    } ent_t;

    ent_t sb[$];
    int   since = 1000;

    function automatic int find_k(int idx, bit used);
        if (!used) return 0;
        if (ZR != 0 && idx == 0) return 0;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].v && sb[i].dst == idx) return i + 1;
        end
        return 0;
    endfunction

    function automatic void model_eval(output bit st, output bit fl, output int k1,
                                       output int k2, output int busy);
        bit lu1;
        bit lu2;
        fl   = in_branch_taken || (since < int'(FC));
        k1   = find_k(int'(in_dc_src1_idx), in_dc_src1_used);
        k2   = find_k(int'(in_dc_src2_idx), in_dc_src2_used);
        lu1  = (k1 != 0) && sb[k1-1].ld && (k1 < int'(LS));
        lu2  = (k2 != 0) && sb[k2-1].ld && (k2 < int'(LS));
        st   = in_dc_valid && !fl && (lu1 || lu2);
        busy = 0;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].v) busy = busy | (1 << sb[i].dst);
        end
    endfunction

    always @(negedge clock) begin
        bit es;
        bit ef;
        int k1;
        int k2;
        int eb;
        if (!reset) begin
            model_eval(es, ef, k1, k2, eb);
            chk("model_flush", int'(out_flush), int'(ef));
            chk("model_stall", int'(out_stall), int'(es));
            chk("model_busy", int'(out_busy_mask), eb);
            if (!es) begin
                chk("model_sel1", int'(out_fwd_src1_sel), k1);
                chk("model_sel2", int'(out_fwd_src2_sel), k2);
            end
        end
    end

    always @(posedge clock) begin
        bit   es;
        bit   ef;
        int   k1;
        int   k2;
        int   eb;
        ent_t e;
        if (reset) begin
            sb.delete();
            for (int i = 0; i < int'(PD); i++) begin
                e.v = 1'b0; e.dst = 0; e.ld = 1'b0;
                sb.push_back(e);
            end
            since = 1000;
        end else begin
            model_eval(es, ef, k1, k2, eb);
            e.v   = in_dc_valid && in_dc_writes && !es && !ef;
            e.dst = int'(in_dc_dst_idx);
            e.ld  = in_dc_is_load;
            sb.push_front(e);
            void'(sb.pop_back());
            since = in_branch_taken ? 1 : ((since < 1000) ? since + 1 : since);
        end
    end

    task automatic drv(bit v, int s1, bit u1, int s2, bit u2, int d, bit w, bit ld, bit br);
        @(posedge clock);
        #1;
        in_dc_valid     = v;
        in_dc_src1_idx  = RW'(s1);
        in_dc_src1_used = u1;
        in_dc_src2_idx  = RW'(s2);
        in_dc_src2_used = u2;
        in_dc_dst_idx   = RW'(d);
        in_dc_writes    = w;
        in_dc_is_load   = ld;
        in_branch_taken = br;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drv_rand();
        drv($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    endtask

    initial begin
        // Reset held two cycles with random inputs
        reset = 1'b1;
        drv_rand();
        drv_rand();
        idle(1);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_flush", int'(out_flush), 0);
        chk("reset_stall", int'(out_stall), 0);
        chk("reset_busy", int'(out_busy_mask), 0);
        chk("reset_sel1", int'(out_fwd_src1_sel), 0);

        // ALU chain on r3: consumers at distance 1..4
        idle(2);
        drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("alu_d1_sel1", int'(out_fwd_src1_sel), 1);
        chk("alu_d1_stall", int'(out_stall), 0);
        chk("alu_d1_busy", int'(out_busy_mask), 16'h0008);
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("alu_d2_sel1", int'(out_fwd_src1_sel), 2);
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("alu_d3_sel1", int'(out_fwd_src1_sel), 3);
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("alu_d4_sel1", int'(out_fwd_src1_sel), 0);

        // Load-use on r5: one stall cycle, then forward from MEM
        idle(3);
        drv(1, 0, 0, 0, 0, 5, 1, 1, 0);
        drv(1, 0, 0, 5, 1, 0, 0, 0, 0);
        @(negedge clock);
        chk("lu_stall", int'(out_stall), 1);
        drv(1, 0, 0, 5, 1, 0, 0, 0, 0);
        @(negedge clock);
        chk("lu_after_stall", int'(out_stall), 0);
        chk("lu_sel2", int'(out_fwd_src2_sel), 2);
        chk("lu_busy", int'(out_busy_mask), 16'h0020);

        // Newest producer wins
        idle(3);
        drv(1, 0, 0, 0, 0, 4, 1, 0, 0);
        drv(1, 0, 0, 0, 0, 7, 1, 0, 0);
        drv(1, 0, 0, 0, 0, 4, 1, 0, 0);
        drv(1, 4, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("newest_sel1", int'(out_fwd_src1_sel), 1);
        chk("newest_busy", int'(out_busy_mask), 16'h0090);

        // Register 0 never hazards or forwards
        idle(3);
        drv(1, 0, 0, 0, 0, 0, 1, 1, 0);
        drv(1, 0, 1, 0, 1, 0, 0, 0, 0);
        @(negedge clock);
        chk("zero_stall", int'(out_stall), 0);
        chk("zero_sel1", int'(out_fwd_src1_sel), 0);
        chk("zero_sel2", int'(out_fwd_src2_sel), 0);
        chk("zero_busy", int'(out_busy_mask), 16'h0001);

        // Single branch: two flush cycles, squashed writes never enter the scoreboard
        idle(3);
        drv(1, 0, 0, 0, 0, 9, 1, 0, 1);
        @(negedge clock);
        chk("flush_c0", int'(out_flush), 1);
        drv(1, 0, 0, 0, 0, 10, 1, 0, 0);
        @(negedge clock);
        chk("flush_c1", int'(out_flush), 1);
        drv(1, 0, 0, 0, 0, 11, 1, 0, 0);
        @(negedge clock);
        chk("flush_c2", int'(out_flush), 0);
        chk("flush_c2_busy", int'(out_busy_mask), 0);
        idle(1);
        @(negedge clock);
        chk("flush_c3_busy", int'(out_busy_mask), 16'h0800);

        // Restart: second branch on the 2nd flush cycle
        idle(3);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        chk("restart_c1", int'(out_flush), 1);
        idle(1);
        @(negedge clock);
        chk("restart_c2", int'(out_flush), 1);
        idle(1);
        @(negedge clock);
        chk("restart_c3", int'(out_flush), 0);

        // Flush beats stall
        idle(3);
        drv(1, 0, 0, 0, 0, 6, 1, 1, 0);
        drv(1, 6, 1, 0, 0, 0, 0, 0, 1);
        @(negedge clock);
        chk("fbs_flush", int'(out_flush), 1);
        chk("fbs_stall", int'(out_stall), 0);

        // Reset mid-flush leaves nothing pending
        idle(3);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_midflush", int'(out_flush), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drv_rand();
            reset = ($urandom_range(0, 199) == 0);
        end
        idle(1);
        reset = 1'b0;
        idle(4);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
